// File: rtl/led_scan_seq.sv
// Scan sequencer that drives a 3-to-8 LED decoder: up, down, ping-pong and single-shot patterns with programmable dwell.
// Optional feature macro: LED_SCAN_PINGPONG_EN (mode 2 is ping-pong when defined, otherwise behaves as mode 0).
module led_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         switch,
  output logic [2:0]         enable,
  output logic               busy,
  output logic               wrap
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         m_reg, m_next;
  logic [DWELL_W-1:0] d_reg, d_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic               dir_reg, dir_next;
  logic [2:0]         sw_reg, sw_next;
  logic               wrap_reg, wrap_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= 2'd0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      sw_reg    <= 3'd0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      sw_reg    <= sw_next;
      wrap_reg  <= wrap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    sw_next    = sw_reg;
    wrap_next  = 1'b0;

    if (stop) begin
      state_next = IDLE;
      sw_next    = 3'd0;
    end else if (start) begin
      m_next     = mode;
      d_next     = dwell;
      cnt_next   = dwell;
      sw_next    = (mode == 2'd1) ? 3'd7 : 3'd0;
      dir_next   = (mode == 2'd1);
      state_next = RUN;
    end else if (state_reg != IDLE) begin
      if (hold) begin
        state_next = PAUSE;
      end else begin
        // Leaving PAUSE counts as a normal step cycle, so each held cycle adds exactly one.
        state_next = RUN;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - DWELL_W'(1);
        end else begin
          cnt_next = d_reg;
          case (m_reg)
            2'd3: begin
              if (sw_reg == 3'd7) begin
                state_next = IDLE;
                sw_next    = 3'd0;
                wrap_next  = 1'b1;
              end else begin
                sw_next = sw_reg + 3'd1;
              end
            end
`ifdef LED_SCAN_PINGPONG_EN
            2'd2: begin
              // Direction flips on arrival at either end; a pass ends on reaching 0.
              if (!dir_reg) begin
                sw_next = sw_reg + 3'd1;
                if (sw_reg == 3'd6) dir_next = 1'b1;
              end else begin
                sw_next = sw_reg - 3'd1;
                if (sw_reg == 3'd1) begin
                  dir_next  = 1'b0;
                  wrap_next = 1'b1;
                end
              end
            end
`endif
            default: begin
              // Up and down share one path; dir was fixed when the scan started.
              if (dir_reg) begin
                sw_next   = sw_reg - 3'd1;
                wrap_next = (sw_reg == 3'd0);
              end else begin
                sw_next   = sw_reg + 3'd1;
                wrap_next = (sw_reg == 3'd7);
              end
            end
          endcase
        end
      end
    end
  end

  assign switch = sw_reg;
  assign enable = (state_reg != IDLE) ? 3'b100 : 3'b000;
  assign busy   = (state_reg != IDLE);
  assign wrap   = wrap_reg;

endmodule

// File: tb/tb_led_scan_seq.sv
// Self-checking bench for led_scan_seq: directed scenarios plus random stimulus against a sequence-table model.
module tb_led_scan_seq;

  logic       clk = 1'b0;
  logic       rst, start, stop, hold;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic [2:0] switch, enable;
  logic       busy, wrap;

  int checks = 0;
  int failures = 0;

  // Model: position k along the pattern and ticks t spent at that position.
  bit         m_act;
  int         m_mode, m_dwell, m_t, m_k;
  logic [2:0] exp_sw;
  logic       exp_wrap;

  led_scan_seq #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .mode(mode), .dwell(dwell), .switch(switch), .enable(enable),
    .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [2:0] pattern(input int md, input int kk);
    if (md == 1) return 3'(7 - kk);
`ifdef LED_SCAN_PINGPONG_EN
    if (md == 2 && kk > 7) return 3'(14 - kk);
`endif
    return 3'(kk);
  endfunction

  function automatic int period(input int md);
`ifdef LED_SCAN_PINGPONG_EN
    if (md == 2) return 14;
`endif
    return 8;
  endfunction

  task automatic model_step();
    exp_wrap = 1'b0;
    if (rst || stop) begin
      m_act = 1'b0;
    end else if (start) begin
      m_act = 1'b1; m_mode = int'(mode); m_dwell = int'(dwell); m_t = 0; m_k = 0;
    end else if (m_act && !hold) begin
      m_t++;
      if (m_t > m_dwell) begin
        m_t = 0;
        m_k++;
        if (m_mode == 3 && m_k == 8) begin
          m_act = 1'b0; exp_wrap = 1'b1;
        end else if (m_k == period(m_mode)) begin
          m_k = 0; exp_wrap = 1'b1;
        end
      end
    end
    exp_sw = m_act ? pattern(m_mode, m_k) : 3'd0;
  endtask

  task automatic cyc(input logic r, input logic s, input logic p, input logic h,
                     input logic [1:0] md, input logic [7:0] dw, input string tag);
    rst = r; start = s; stop = p; hold = h; mode = md; dwell = dw;
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".switch"}, 32'(switch), 32'(exp_sw));
    chk({tag, ".enable"}, 32'(enable), m_act ? 32'h4 : 32'h0);
    chk({tag, ".busy"},   32'(busy),   32'(m_act));
    chk({tag, ".wrap"},   32'(wrap),   32'(exp_wrap));
  endtask

  int busy_cycles;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 2'd0; dwell = 8'd0;
    m_act = 1'b0; m_mode = 0; m_dwell = 0; m_t = 0; m_k = 0; exp_sw = 3'd0; exp_wrap = 1'b0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, "rst");
    cyc(1, 0, 0, 0, 0, 0, "rst");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, "idle");

    // Up, dwell 0: one index per cycle, wrap on return to 0.
    cyc(0, 1, 0, 0, 2'd0, 8'd0, "up_start");
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 2'd1, 8'd5, "up");

    // Down, dwell 2.
    cyc(0, 1, 0, 0, 2'd1, 8'd2, "down_start");
    for (int i = 0; i < 27; i++) cyc(0, 0, 0, 0, 2'd0, 8'd0, "down");

    // Ping-pong (or up when the feature is compiled out), dwell 0.
    cyc(0, 1, 0, 0, 2'd2, 8'd0, "pp_start");
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, 2'd0, 8'd0, "pp");

    // Single-shot, dwell 1: busy for exactly 16 cycles.
    cyc(0, 1, 0, 0, 2'd3, 8'd1, "ss_start");
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 2'd0, 8'd0, "ss");
      if (busy) busy_cycles++;
    end
    chk("ss.busy_cycles", 32'(busy_cycles), 32'd16);

    // Hold mid-step, resume, then stop while paused.
    cyc(0, 1, 0, 0, 2'd0, 8'd3, "hold_start");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 2'd0, 8'd0, "hold_pre");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 2'd0, 8'd0, "hold_on");
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 2'd0, 8'd0, "hold_post");
    cyc(0, 0, 0, 1, 2'd0, 8'd0, "pause");
    cyc(0, 0, 1, 1, 2'd0, 8'd0, "pause_stop");
    cyc(0, 0, 0, 0, 2'd0, 8'd0, "after_stop");
    cyc(0, 1, 1, 0, 2'd0, 8'd0, "start_stop");
    cyc(0, 0, 0, 0, 2'd0, 8'd0, "start_stop_idle");

    // Reset in the middle of a run.
    cyc(0, 1, 0, 0, 2'd0, 8'd1, "rr_start");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 2'd0, 8'd0, "rr_run");
    cyc(1, 0, 0, 0, 2'd0, 8'd0, "rr_rst");
    cyc(0, 0, 0, 0, 2'd0, 8'd0, "rr_idle");

    // Random stimulus; mode/dwell wiggle freely since they only matter at start.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 79) == 0),
          ($urandom_range(0, 5) == 0),
          2'($urandom_range(0, 3)),
          8'($urandom_range(0, 3)),
          "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_scan_seq.md
# led_scan_seq

Upstream control stage for the 3-to-8 active-low LED decoder. Generates the decoder's `switch` index and `enable` code so one LED at a time is lit in a programmable scan pattern (up, down, ping-pong, single-shot) with programmable dwell per position. Outputs connect directly to the decoder's `switch[2:0]` and `enable[2:0]` inputs, on the same clock.

## Interface
- `DWELL_W`, default 8: width of the dwell count; each position is held for `dwell+1` cycles.

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin (or restart) a scan; samples `mode` and `dwell`
- `stop`  in  1  abort scan, return to IDLE
- `hold`  in  1  level; freezes the scan while high (RUN only)
- `mode`  in  2  0 = up, 1 = down, 2 = ping-pong, 3 = single-shot up
- `dwell`  in  DWELL_W  cycles-per-position minus 1
- `switch`  out  3  LED index to decoder (registered)
- `enable`  out  3  decoder enable: 3'b100 when scanning, 3'b000 when idle (all LEDs off)
- `busy`  out  1  high in RUN or PAUSE
- `wrap`  out  1  one-cycle pulse at end of a full pass

## Operation
- States: IDLE, RUN, PAUSE. Internal regs: latched mode `m`, latched dwell `d`, down-counter `cnt`, direction bit `dir` (0 = up).
- Priority per cycle: `rst` > `stop` > `start` > `hold` > normal stepping.
- IDLE: `switch`=0, `enable`=000, `busy`=0. On `start`: latch `m`,`d`; `cnt`←`d`; `switch`←7 if `m`=1, else 0; `dir`←(`m`=1); go RUN.
- RUN: if `cnt`≠0, decrement. If `cnt`=0, step the index and reload `cnt`←`d`:
  - up: 7→0 wraps, `wrap`=1.
  - down: 0→7 wraps, `wrap`=1.
  - ping-pong: 0..7 then 6..1, 0; reverse `dir` at 7 and at 0; `wrap`=1 on the 1→0 step.
  - single-shot: 0..7; when `cnt`=0 at index 7, go IDLE (`switch`←0, `enable`←000), `wrap`=1.
- `hold`=1 in RUN: go PAUSE, `cnt` and `switch` frozen, `enable` stays 100. `hold`=0 in PAUSE: return to RUN and continue with the remaining count. No stepping occurs in the cycle `hold` is sampled high.
- `start` in RUN/PAUSE: full restart as from IDLE, with new `mode`/`dwell`.
- `stop` in RUN/PAUSE: IDLE next cycle. `wrap` is not pulsed.
- `mode`/`dwell` changes mid-scan are ignored until the next `start`.
- Index arithmetic is 3-bit modulo 8. `cnt` is DWELL_W bits, with no saturation concerns (reload only).

## Timing
- Reset values: `switch`=0, `enable`=000, `busy`=0, `wrap`=0, state IDLE, `dir`=0, `cnt`=0.
- `start` sampled at edge n: from n+1, `enable`=100, `busy`=1, and the first index is valid.
- Each index is held for exactly `dwell+1` cycles in RUN. PAUSE cycles extend the hold.
- `wrap` is registered. It is high during the first cycle the new (wrapped) index is shown, or the first IDLE cycle after single-shot completion.
- Single-shot, dwell=d: `busy` is high for exactly 8·(d+1) cycles.
- Full ping-pong period: 14·(d+1) cycles.

## Configuration
- `LED_SCAN_PINGPONG_EN` defined: mode 2 is ping-pong as described.
- Not defined: mode 2 behaves identically to mode 0 (up), `dir` is fixed at the value from `start`, and the reversal logic is removed.

## Test plan
- `rst`=1 for 2 cycles, then idle → `switch`=0, `enable`=000, `busy`=0, `wrap`=0. Check that `rst` asserted mid-RUN gives the same values next cycle.
- mode 0, dwell 0, `start` pulse → `switch` = 0,1,…,7,0 on consecutive cycles. `wrap`=1 only on the cycle `switch` returns to 0. `enable`=100 throughout.
- mode 1, dwell 2 → `switch` = 7,7,7,6,6,6,…,0,0,0,7. `wrap` is high on the first cycle of the second 7.
- mode 2, dwell 0, with `LED_SCAN_PINGPONG_EN` defined → `switch` = 0..7,6..1,0. `wrap` is high at that 0, and the period is 14. Without the macro, the sequence matches mode 0.
- mode 3, dwell 1 → 16 cycles with `busy`=1 (0,0,1,1,…,7,7). Then `enable`=000, `switch`=0, `busy`=0, with a single `wrap` pulse.
- mode 0, dwell 3: raise `hold` for 5 cycles mid-step → `switch` is frozen and the step resumes with the remaining count. `stop` during PAUSE → IDLE next cycle with no `wrap`. `start`+`stop` in the same cycle → stays IDLE.
